// File: rtl/hash_pkg.sv
// Shared types and helpers for the hash fold pipeline.
package hash_pkg;

  typedef enum logic [1:0] {
    MODE_SUM      = 2'd0,
    MODE_XOR      = 2'd1,
    MODE_SEED_SUM = 2'd2,
    MODE_ROT_XOR  = 2'd3
  } hash_mode_e;

  // Widest chunk the rotate helper supports.
  localparam int MAX_W = 64;

  // Accumulator wide enough for N_CHUNK chunks plus one seed without overflow.
  function automatic int acc_w(input int key_w, input int out_w);
    return out_w + $clog2(key_w / out_w + 1);
  endfunction

  // Rotate the low w bits of x left by s (0 <= s < w); bits above w return zero.
  function automatic logic [MAX_W-1:0] rotl(input logic [MAX_W-1:0] x,
                                            input int unsigned w,
                                            input int unsigned s);
    logic [MAX_W-1:0] mask;
    logic [MAX_W-1:0] xm;
    mask = (w >= MAX_W) ? '1 : ((MAX_W'(1) << w) - MAX_W'(1));
    xm   = x & mask;
    return ((xm << s) | (xm >> (w - s))) & mask;
  endfunction

endpackage

// File: rtl/hash_fold_stage.sv
// One end-around fold register: acc <= acc[OUT_W-1:0] + (acc >> OUT_W), with valid and tag.
module hash_fold_stage #(
  parameter int ACC_W = 12,
  parameter int OUT_W = 8,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             in_valid,
  input  logic [ACC_W-1:0] in_acc,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  output logic [ACC_W-1:0] out_acc,
  output logic [TAG_W-1:0] out_tag
);

  logic [ACC_W-1:0] folded;

  assign folded = ACC_W'(in_acc[OUT_W-1:0]) + (in_acc >> OUT_W);

  // Shift one step when the pipe advances; payload only loads for real entries.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_acc   <= '0;
      out_tag   <= '0;
    end else if (en) begin
      out_valid <= in_valid;
      if (in_valid) begin
        out_acc <= folded;
        out_tag <= in_tag;
      end
    end
  end

endmodule

// File: rtl/hash_fold_pipe.sv
// Pipelined key hash: reduce KEY_W-bit key to an accumulator, then fold it down to OUT_W bits.
//
// Handshake: an input is taken on a clock edge where in_valid_i && in_ready_o; a result is
// taken on an edge where out_valid_o && out_ready_i. The whole pipe advances together under
// en = !out_valid_o || out_ready_i, so a stalled result holds hash_o/tag_o steady and
// in_ready_o is low for the same cycles.
module hash_fold_pipe
  import hash_pkg::*;
#(
  parameter int KEY_W       = 64,
  parameter int OUT_W       = 8,
  parameter int TAG_W       = 4,
  parameter int FOLD_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [KEY_W-1:0] key_i,
  input  logic [1:0]       mode_i,
  input  logic [OUT_W-1:0] seed_i,
  input  logic [TAG_W-1:0] tag_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [OUT_W-1:0] hash_o,
  output logic [TAG_W-1:0] tag_o,
  output logic             busy_o
);

  localparam int N_CHUNK = KEY_W / OUT_W;
  localparam int ACC_W   = acc_w(KEY_W, OUT_W);

  if (KEY_W % OUT_W != 0) begin : g_bad_key_w
    $error("hash_fold_pipe: KEY_W must be a multiple of OUT_W");
  end
  if (N_CHUNK < 2) begin : g_bad_n_chunk
    $error("hash_fold_pipe: KEY_W/OUT_W must be at least 2");
  end
  if (FOLD_STAGES < 1) begin : g_bad_fold
    $error("hash_fold_pipe: FOLD_STAGES must be at least 1");
  end
  if (OUT_W > MAX_W) begin : g_bad_out_w
    $error("hash_fold_pipe: OUT_W exceeds rotate helper width");
  end

  logic             en;
  logic [ACC_W-1:0] sum_acc;
  logic [OUT_W-1:0] xor_acc;
  logic [OUT_W-1:0] rot_acc;
  logic [ACC_W-1:0] red_acc;

  logic             r_valid;
  logic [ACC_W-1:0] r_acc;
  logic [TAG_W-1:0] r_tag;

  // Index 0 is the reduce register, 1..FOLD_STAGES the fold registers.
  logic [FOLD_STAGES:0] st_valid;
  logic [ACC_W-1:0]     st_acc [FOLD_STAGES+1];
  logic [TAG_W-1:0]     st_tag [FOLD_STAGES+1];

  assign en         = !out_valid_o || out_ready_i;
  assign in_ready_o = en;

  // Reduce all chunks of the key according to the selected mode.
  always_comb begin
    sum_acc = '0;
    xor_acc = '0;
    rot_acc = '0;
    red_acc = '0;
    for (int i = 0; i < N_CHUNK; i++) begin
      sum_acc = sum_acc + ACC_W'(key_i[i*OUT_W +: OUT_W]);
      xor_acc = xor_acc ^ key_i[i*OUT_W +: OUT_W];
      rot_acc = rot_acc ^ OUT_W'(rotl(MAX_W'(key_i[i*OUT_W +: OUT_W]), OUT_W, i % OUT_W));
    end
    case (hash_mode_e'(mode_i))
      MODE_SUM:      red_acc = sum_acc;
      MODE_XOR:      red_acc = ACC_W'(xor_acc);
      MODE_SEED_SUM: red_acc = sum_acc + ACC_W'(seed_i);
      MODE_ROT_XOR:  red_acc = ACC_W'(rot_acc);
      default:       red_acc = sum_acc;
    endcase
  end

  // Reduce register: captures the key's accumulator when the input handshake fires.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_acc   <= '0;
      r_tag   <= '0;
    end else if (en) begin
      r_valid <= in_valid_i;
      if (in_valid_i) begin
        r_acc <= red_acc;
        r_tag <= tag_i;
      end
    end
  end

  assign st_valid[0] = r_valid;
  assign st_acc[0]   = r_acc;
  assign st_tag[0]   = r_tag;

  for (genvar g = 0; g < FOLD_STAGES; g++) begin : g_fold
    hash_fold_stage #(
      .ACC_W (ACC_W),
      .OUT_W (OUT_W),
      .TAG_W (TAG_W)
    ) u_stage (
      .clk       (clk),
      .rst       (rst),
      .en        (en),
      .in_valid  (st_valid[g]),
      .in_acc    (st_acc[g]),
      .in_tag    (st_tag[g]),
      .out_valid (st_valid[g+1]),
      .out_acc   (st_acc[g+1]),
      .out_tag   (st_tag[g+1])
    );
  end

  assign out_valid_o = st_valid[FOLD_STAGES];
  assign hash_o      = st_acc[FOLD_STAGES][OUT_W-1:0];
  assign tag_o       = st_tag[FOLD_STAGES];
  assign busy_o      = |st_valid;

endmodule

// File: tb/tb_hash_fold_pipe.sv
// Directed and scoreboard bench for hash_fold_pipe (default and wide configurations).
module tb_hash_fold_pipe;

  // Clock and reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Default configuration DUT signals
  logic        in_valid, in_ready, out_valid, out_ready, busy;
  logic [63:0] key;
  logic [1:0]  mode;
  logic [7:0]  seed, hash;
  logic [3:0]  tag, tag_out;

  // Wide configuration DUT signals
  logic         vb, rb, ovb, orb, busyb;
  logic [127:0] keyb;
  logic [1:0]   modeb;
  logic [15:0]  seedb, hashb;
  logic [3:0]   tagb, tagob;

  hash_fold_pipe u_dut (
    .clk(clk), .rst(rst), .in_valid_i(in_valid), .in_ready_o(in_ready), .key_i(key),
    .mode_i(mode), .seed_i(seed), .tag_i(tag), .out_valid_o(out_valid),
    .out_ready_i(out_ready), .hash_o(hash), .tag_o(tag_out), .busy_o(busy)
  );

  hash_fold_pipe #(.KEY_W(128), .OUT_W(16), .TAG_W(4), .FOLD_STAGES(3)) u_dut_wide (
    .clk(clk), .rst(rst), .in_valid_i(vb), .in_ready_o(rb), .key_i(keyb),
    .mode_i(modeb), .seed_i(seedb), .tag_i(tagb), .out_valid_o(ovb),
    .out_ready_i(orb), .hash_o(hashb), .tag_o(tagob), .busy_o(busyb)
  );

  // Scoreboards: {tag, hash}
  logic [11:0] exp_q[$];
  logic [19:0] exp_qb[$];

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [63:0] key;
    logic [1:0]  mode;
    logic [7:0]  seed;
    logic [7:0]  exp;
  } vec_t;
  vec_t vecs[11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference hash for the 128/16/3 configuration.
  function automatic logic [15:0] ref_b(input logic [127:0] k, input logic [1:0] m,
                                        input logic [15:0] s);
    logic [31:0] acc;
    logic [15:0] c, x;
    acc = 0;
    x   = 0;
    for (int i = 0; i < 8; i++) begin
      c = k[i*16 +: 16];
      if (m == 2'd0 || m == 2'd2) acc = acc + 32'(c);
      else if (m == 2'd1) x = x ^ c;
      else x = x ^ ((c << i) | (c >> (16 - i)));
    end
    if (m == 2'd2) acc = acc + 32'(s);
    if (m == 2'd1 || m == 2'd3) acc = 32'(x);
    repeat (3) acc = (acc & 32'hFFFF) + (acc >> 16);
    return acc[15:0];
  endfunction

  // Driver: one key on the default DUT, then wait for its result.
  task automatic run_vec(input logic [63:0] k, input logic [1:0] m, input logic [7:0] s,
                         input logic [3:0] t, input logic [7:0] exp, input string name);
    int lat;
    @(negedge clk);
    key = k; mode = m; seed = s; tag = t; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    check({name, " latency"}, lat, 3);
    check({name, " hash"}, 32'(hash), 32'(exp));
    check({name, " tag"}, 32'(tag_out), 32'(t));
  endtask

  initial begin
    int pushed, got, stall, bad, lat, prev_hold;
    logic [7:0]  prev_hash;
    logic [3:0]  prev_tag;
    logic [11:0] e;
    logic [19:0] eb;

    vecs[0]  = '{64'h0102030405060708, 2'd0, 8'h00, 8'h24};
    vecs[1]  = '{64'hFFFFFFFFFFFFFFFF, 2'd0, 8'h00, 8'hFF};
    vecs[2]  = '{64'hFF01000000000000, 2'd0, 8'h00, 8'h01};
    vecs[3]  = '{64'h0000000000000001, 2'd2, 8'hFF, 8'h01};
    vecs[4]  = '{64'h0102030405060708, 2'd1, 8'h00, 8'h08};
    vecs[5]  = '{64'h0101010101010101, 2'd3, 8'h00, 8'hFF};
    vecs[6]  = '{64'hFFFFFFFFFFFFFFFF, 2'd1, 8'h00, 8'h00};
    vecs[7]  = '{64'h0000000000000000, 2'd2, 8'h10, 8'h10};
    vecs[8]  = '{64'h0000000000000080, 2'd3, 8'h00, 8'h80};
    vecs[9]  = '{64'h8000000000000000, 2'd3, 8'h00, 8'h40};
    vecs[10] = '{64'h000000000000FFFF, 2'd0, 8'h55, 8'hFF};

    // Reset
    rst = 1'b1;
    in_valid = 0; key = 0; mode = 0; seed = 0; tag = 0; out_ready = 1;
    vb = 0; keyb = 0; modeb = 0; seedb = 0; tagb = 0; orb = 1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset out_valid", 32'(out_valid), 0);
    check("reset busy", 32'(busy), 0);
    check("reset hash", 32'(hash), 0);
    check("reset tag", 32'(tag_out), 0);
    check("reset wide out_valid", 32'(ovb), 0);
    rst = 1'b0;

    // Directed vectors
    foreach (vecs[i])
      run_vec(vecs[i].key, vecs[i].mode, vecs[i].seed, 4'(i), vecs[i].exp, $sformatf("vec%0d", i));

    // Back-to-back keys with a 5-cycle output stall
    pushed = 0; got = 0; stall = 0; prev_hold = 0; prev_hash = 0; prev_tag = 0;
    for (int c = 0; c < 40 && got < 4; c++) begin
      @(negedge clk);
      if (prev_hold != 0) begin
        check("stall hash stable", 32'(hash), 32'(prev_hash));
        check("stall tag stable", 32'(tag_out), 32'(prev_tag));
      end
      in_valid = (pushed < 4);
      key = 64'(pushed + 1); mode = 2'd0; seed = 0; tag = 4'(pushed);
      if (out_valid && stall < 5) begin
        out_ready = 1'b0;
        stall++;
      end else begin
        out_ready = 1'b1;
      end
      #1;
      if (!out_ready) check("stall in_ready", 32'(in_ready), 0);
      if (in_valid && in_ready) begin
        exp_q.push_back({4'(pushed), 8'(pushed + 1)});
        pushed++;
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) check("stall unexpected output", 1, 0);
        else begin
          e = exp_q.pop_front();
          check("stall order", {20'd0, tag_out, hash}, 32'(e));
        end
        got++;
      end
      prev_hold = (out_valid && !out_ready) ? 1 : 0;
      prev_hash = hash;
      prev_tag  = tag_out;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    check("stall results count", got, 4);
    check("stall stall cycles", stall, 5);

    // Reset with entries in flight
    @(negedge clk);
    in_valid = 1; key = 64'h1; mode = 0; tag = 4'd5;
    @(negedge clk);
    check("inflight busy", 32'(busy), 1);
    key = 64'h2; tag = 4'd6;
    @(negedge clk);
    in_valid = 0; rst = 1;
    @(negedge clk);
    rst = 0;
    check("rst drop out_valid", 32'(out_valid), 0);
    check("rst drop busy", 32'(busy), 0);
    bad = 0;
    repeat (6) begin
      @(negedge clk);
      if (out_valid) bad = 1;
    end
    check("rst no stale output", bad, 0);
    run_vec(64'h0102030405060708, 2'd0, 8'h00, 4'd9, 8'h24, "after rst");

    // Wide configuration: all-ones key, latency 4
    @(negedge clk);
    keyb = '1; modeb = 0; seedb = 0; tagb = 4'd3; vb = 1; orb = 1;
    @(negedge clk);
    vb = 0;
    lat = 1;
    while (!ovb && lat < 12) begin
      @(negedge clk);
      lat++;
    end
    check("wide latency", lat, 4);
    check("wide all-ones hash", 32'(hashb), 32'hFFFF);
    check("wide all-ones tag", 32'(tagob), 3);

    // Wide configuration: random keys and modes with random backpressure
    prev_hold = 0; got = 0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      if (prev_hold == 0) begin
        vb    = (c < 300) && ($urandom_range(0, 3) != 0);
        keyb  = {$urandom(), $urandom(), $urandom(), $urandom()};
        if ($urandom_range(0, 9) == 0) keyb = '1;
        modeb = 2'($urandom_range(0, 3));
        seedb = 16'($urandom_range(0, 65535));
        tagb  = 4'($urandom_range(0, 15));
      end
      orb = ($urandom_range(0, 3) != 0) || (c >= 300);
      #1;
      if (vb && rb) exp_qb.push_back({tagb, ref_b(keyb, modeb, seedb)});
      prev_hold = (vb && !rb) ? 1 : 0;
      if (ovb && orb) begin
        if (exp_qb.size() == 0) check("wide unexpected output", 1, 0);
        else begin
          eb = exp_qb.pop_front();
          check("wide random", {12'd0, tagob, hashb}, 32'(eb));
        end
        got++;
      end
    end
    vb = 0;
    check("wide drained", exp_qb.size(), 0);
    check("wide got outputs", 32'(got > 50), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
